// File: rtl/count_ctrl_if.sv
// Control/config/status bundle for count_ctrl: master drives commands and config,
// slave (the counter) returns count and status flags.
interface count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_mode;
    logic             cfg_dir;
    logic             start;
    logic             stop;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             busy;
    logic             tc;
    logic             done;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_limit, cfg_mode, cfg_dir, start, stop, clear,
        input  count, cnt_en, busy, tc, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_limit, cfg_mode, cfg_dir, start, stop, clear,
        output count, cnt_en, busy, tc, done, cfg_err
    );
endinterface

// File: rtl/count_ctrl.sv
// Configurable up/down terminal counter with one-shot/periodic modes and
// IDLE/RUN/PAUSE/DONE control; every output comes straight from a flop.
module count_ctrl #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rstn,
    count_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count_q, count_nx;
    logic [WIDTH-1:0] limit_q, limit_nx;
    logic             mode_q, mode_nx;
    logic             dir_q, dir_nx;
    logic             tc_q, tc_nx;
    logic             err_q, err_nx;
    logic             cnt_en_q, busy_q, done_q;
    logic             wr_cfg;
    logic [WIDTH-1:0] start_val, term_val;

    always_comb begin
        state_nx  = state;
        count_nx  = count_q;
        tc_nx     = 1'b0;
        err_nx    = 1'b0;
        wr_cfg    = 1'b0;
        start_val = dir_q ? limit_q : '0;
        term_val  = dir_q ? '0 : limit_q;

        if (bus.clear) begin
            state_nx = IDLE;
            count_nx = '0;
        end else if (bus.stop && state == RUN) begin
            state_nx = PAUSE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (limit_q != '0) begin
                            state_nx = RUN;
                            count_nx = start_val;
                        end else begin
                            // rejected start: a simultaneous config write still lands
                            err_nx = 1'b1;
                            wr_cfg = bus.cfg_we;
                        end
                    end else begin
                        wr_cfg = bus.cfg_we;
                    end
                end
                PAUSE: begin
                    if (bus.start)       state_nx = RUN;
                    else if (bus.cfg_we) err_nx   = 1'b1;
                end
                RUN: begin
                    err_nx = bus.cfg_we;
                    // periodic mode reloads right after the terminal value, no gap
                    if (count_q == term_val) count_nx = start_val;
                    else if (dir_q)          count_nx = count_q - WIDTH'(1);
                    else                     count_nx = count_q + WIDTH'(1);
                    if (count_nx == term_val) begin
                        tc_nx = 1'b1;
                        if (!mode_q) state_nx = DONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        limit_nx = wr_cfg ? bus.cfg_limit : limit_q;
        mode_nx  = wr_cfg ? bus.cfg_mode  : mode_q;
        dir_nx   = wr_cfg ? bus.cfg_dir   : dir_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            count_q  <= '0;
            limit_q  <= '1;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            count_q  <= count_nx;
            limit_q  <= limit_nx;
            mode_q   <= mode_nx;
            dir_q    <= dir_nx;
            tc_q     <= tc_nx;
            err_q    <= err_nx;
            cnt_en_q <= (state_nx == RUN);
            busy_q   <= (state_nx == RUN) || (state_nx == PAUSE);
            done_q   <= (state_nx == DONE);
        end
    end

    assign bus.count   = count_q;
    assign bus.cnt_en  = cnt_en_q;
    assign bus.busy    = busy_q;
    assign bus.tc      = tc_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboarded bench for count_ctrl: directed scenarios plus random commands,
// checked against a position-modulo reference model.
module tb_count_ctrl;
    localparam int W = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    typedef struct packed {
        int           cyc;
        logic [W+4:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    count_ctrl_if #(.WIDTH(W)) bus();
    count_ctrl #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    exp_t q[$];
    int   edges = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // reference model: position within the period instead of a count register
    int m_lim, m_mode, m_dir, m_st, m_pos, m_cnt;
    bit m_tc, m_err;

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [W+4:0] dut_vec();
        return {bus.count, bus.cnt_en, bus.busy, bus.tc, bus.done, bus.cfg_err};
    endfunction

    function automatic logic [W+4:0] model_vec();
        return {W'(m_cnt), m_st == S_RUN, (m_st == S_RUN) || (m_st == S_PAUSE),
                m_tc, m_st == S_DONE, m_err};
    endfunction

    function automatic void model_reset();
        m_lim = (1 << W) - 1; m_mode = 0; m_dir = 0;
        m_st = S_IDLE; m_pos = 0; m_cnt = 0; m_tc = 0; m_err = 0;
    endfunction

    function automatic void model_step(bit we, int lim, bit mode, bit dir,
                                       bit st, bit sp, bit cl);
        int old = m_st;
        bit adv = (old == S_RUN);
        bit idle_like = (old == S_IDLE) || (old == S_DONE);
        m_tc = 0; m_err = 0;
        if (cl) begin
            m_st = S_IDLE; m_cnt = 0; adv = 0;
        end else if (sp && old == S_RUN) begin
            m_st = S_PAUSE; adv = 0;
        end else if (st && idle_like) begin
            if (m_lim != 0) begin
                m_st = S_RUN; m_pos = 0; m_cnt = m_dir ? m_lim : 0;
            end else begin
                m_err = 1;
                if (we) begin m_lim = lim; m_mode = mode; m_dir = dir; end
            end
        end else if (st && old == S_PAUSE) begin
            m_st = S_RUN;
        end else if (we) begin
            if (idle_like) begin m_lim = lim; m_mode = mode; m_dir = dir; end
            else m_err = 1;
        end
        if (adv) begin
            m_pos = (m_pos + 1) % (m_lim + 1);
            m_cnt = m_dir ? m_lim - m_pos : m_pos;
            if (m_pos == m_lim) begin
                m_tc = 1;
                if (m_mode == 0) m_st = S_DONE;
            end
        end
    endfunction

    task automatic check(input string name, input logic [W+4:0] got, input logic [W+4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: {count,cnt_en,busy,tc,done,cfg_err} got=%b required=%b", name, got, exp);
        end
    endtask

    // one clock of stimulus; expected result for the coming edge goes to the scoreboard
    task automatic cyc(input bit we, input int lim, input bit mode, input bit dir,
                       input bit st, input bit sp, input bit cl);
        bus.cfg_we = we; bus.cfg_limit = W'(lim); bus.cfg_mode = mode; bus.cfg_dir = dir;
        bus.start = st; bus.stop = sp; bus.clear = cl;
        if (rstn) model_step(we, lim, mode, dir, st, sp, cl);
        else      model_reset();
        q.push_back('{cyc: edges + 1, v: model_vec()});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int lim, input bit mode, input bit dir);
        cyc(1, lim, mode, dir, 0, 0, 0);
    endtask

    task automatic go();
        cyc(0, 0, 0, 0, 1, 0, 0);
    endtask

    // monitor: compares every scoreboard entry whose edge has happened
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edges) begin
                e = q.pop_front();
                check($sformatf("scoreboard_edge%0d", e.cyc), dut_vec(), e.v);
            end
        end
    end

    initial begin
        bus.cfg_we = 0; bus.cfg_limit = '0; bus.cfg_mode = 0; bus.cfg_dir = 0;
        bus.start = 0; bus.stop = 0; bus.clear = 0;
        model_reset();
        #12 check("reset_state", dut_vec(), '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // up one-shot over the full range
        cfg(15, 0, 0); go(); idle(18);
        // down periodic, limit 3
        cfg(3, 1, 1); go(); idle(12);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // pause at 5 for three cycles, then resume
        cfg(9, 0, 0); go(); idle(5);
        cyc(0, 0, 0, 0, 0, 1, 0); idle(2); go(); idle(6);
        // config write while running, then zero-limit start
        cfg(2, 0, 0); go(); cyc(1, 7, 1, 1, 0, 0, 0); idle(4);
        cfg(0, 0, 0); go(); idle(2);
        // clear+stop+start together at count 7
        cfg(15, 1, 0); go(); idle(7);
        cyc(0, 0, 0, 0, 1, 1, 1); idle(3);
        // asynchronous reset between edges at count 4
        cfg(15, 0, 0); go(); idle(4);
        #2 rstn = 1'b0;
        #1 check("async_reset_midcount", dut_vec(), '0);
        q.delete();
        model_reset();
        @(posedge clk); #1;
        idle(2);
        rstn = 1'b1;
        idle(4);
        check("idle_after_reset_release", dut_vec(), '0);

        // random command mix
        for (int i = 0; i < 800; i++) begin
            bit we = ($urandom % 6) == 0;
            int lim = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 15));
            bit md = $urandom % 2;
            bit dr = $urandom % 2;
            bit st = ($urandom % 4) == 0;
            bit sp = ($urandom % 8) == 0;
            bit cl = ($urandom % 25) == 0;
            cyc(we, lim, md, dr, st, sp, cl);
        end

        idle(2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
